// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - handshaked execute unit: single-cycle base ALU ops, iterative RV32M mul/div
module alu_seq_muldiv #(
    parameter int XLEN     = 32,
    parameter bit EARLY_DZ = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [2:0]      ALUControl,
    input  logic            is_muldiv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            busy
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic [SHW-1:0]    cnt;
    logic [2:0]        op_f3;
    logic              neg_res;
    logic              spec;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   fix_val;

    logic              is_div, b_zero, div_ovf, in_spec;
    logic [XLEN-1:0]   in_spec_val;
    logic              sgn_a, sgn_b, neg_a, neg_b, neg_res_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [SHW-1:0]    shamt;
    logic              lt;

    // Base ALU
    always_comb begin
        shamt   = B[SHW-1:0];
        lt      = funct3[0] ? (A < B) : ($signed(A) < $signed(B));
        alu_res = '0;
        case (ALUControl)
            3'b000:  alu_res = A + B;
            3'b001:  alu_res = A + ~B + XLEN'(1);
            3'b010:  alu_res = A & B;
            3'b011:  alu_res = A | B;
            3'b100:  alu_res = A ^ B;
            3'b101:  alu_res = {{(XLEN-1){1'b0}}, lt};
            default: begin
                if (!funct3[2])
                    alu_res = A << shamt;
                else if (funct7_5)
                    alu_res = $signed(A) >>> shamt;
                else
                    alu_res = A >> shamt;
            end
        endcase
    end

    // Operand conditioning on accept: magnitudes, result sign, RISC-V special cases
    always_comb begin
        is_div      = funct3[2];
        b_zero      = (B == '0);
        div_ovf     = !funct3[0] && (A == MIN_VAL) && (B == '1);
        in_spec     = is_div && (b_zero || div_ovf);
        if (b_zero)
            in_spec_val = funct3[1] ? A : '1;
        else
            in_spec_val = funct3[1] ? '0 : MIN_VAL;
        sgn_a       = is_div ? !funct3[0] : (funct3 == 3'b001 || funct3 == 3'b010);
        sgn_b       = is_div ? !funct3[0] : (funct3 == 3'b001);
        neg_a       = sgn_a & A[XLEN-1];
        neg_b       = sgn_b & B[XLEN-1];
        mag_a       = neg_a ? -A : A;
        mag_b       = neg_b ? -B : B;
        neg_res_in  = (is_div && funct3[1]) ? neg_a : (neg_a ^ neg_b);
    end

    // One shift-add or restoring-divide step per CALC cycle
    logic [XLEN:0] msum, trial, diff;
    always_comb begin
        msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
        trial   = acc[2*XLEN-1:XLEN-1];
        diff    = trial - {1'b0, opnd};
        acc_nxt = {msum, acc[XLEN-1:1]};
        if (op_f3[2])
            acc_nxt = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem;
    always_comb begin
        prod_s = neg_res ? -acc : acc;
        quo    = acc[XLEN-1:0];
        rem    = acc[2*XLEN-1:XLEN];
        if (spec)
            fix_val = spec_val;
        else if (!op_f3[2])
            fix_val = (op_f3 == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else if (op_f3[1])
            fix_val = neg_res ? -rem : rem;
        else
            fix_val = neg_res ? -quo : quo;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = in_valid && (state == IDLE);
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE: if (accept) begin
                if (!is_muldiv || (EARLY_DZ && in_spec))
                    state_nxt = DONE;
                else
                    state_nxt = CALC;
            end
            CALC: if (cnt == SHW'(XLEN-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            Result   <= '0;
            Zero     <= 1'b1;
            acc      <= '0;
            opnd     <= '0;
            op_f3    <= '0;
            neg_res  <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (!is_muldiv) begin
                        Result <= alu_res;
                        Zero   <= (alu_res == '0);
                    end else begin
                        op_f3    <= funct3;
                        neg_res  <= neg_res_in;
                        spec     <= in_spec;
                        spec_val <= in_spec_val;
                        cnt      <= '0;
                        acc      <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        opnd     <= is_div ? mag_b : mag_a;
                        if (EARLY_DZ && in_spec) begin
                            Result <= in_spec_val;
                            Zero   <= (in_spec_val == '0);
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + SHW'(1);
                end
                FIX: begin
                    Result <= fix_val;
                    Zero   <= (fix_val == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb/tb_alu_seq_muldiv.sv - directed self-checking bench for alu_seq_muldiv
module tb_alu_seq_muldiv;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [2:0]  ALUControl;
    logic        is_muldiv;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Zero;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_seq_muldiv #(.XLEN(32), .EARLY_DZ(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .funct3(funct3), .funct7_5(funct7_5), .ALUControl(ALUControl),
        .is_muldiv(is_muldiv), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .Zero(Zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f75, input logic [2:0] aluc,
                          input logic md, input logic [31:0] exp_res, input int exp_lat,
                          input int hold);
        int  lat;
        bit  seen;
        @(negedge clk);
        A = a; B = b; funct3 = f3; funct7_5 = f75; ALUControl = aluc; is_muldiv = md;
        in_valid = 1'b1;
        lat = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            A = 32'hDEAD_BEEF; B = 32'h1234_5678;
            if (out_valid) seen = 1;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, Result, exp_res);
        check({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp_res == 32'h0});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_res"}, Result, exp_res);
            check({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        int ov_seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; funct3 = '0; funct7_5 = 1'b0; ALUControl = '0; is_muldiv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_result", Result, 32'h0);
        check("rst_zero", {31'b0, Zero}, 32'h1);
        reset = 1'b0;

        //     tag       A             B             f3      f75   aluc    md    expected      lat hold
        run_op("add",    32'd7,        32'd5,        3'b000, 1'b0, 3'b000, 1'b0, 32'd12,        1,  0);
        run_op("sub",    32'd5,        32'd5,        3'b000, 1'b0, 3'b001, 1'b0, 32'd0,         1,  0);
        run_op("sra",    32'h8000_0000,32'd4,        3'b101, 1'b1, 3'b110, 1'b0, 32'hF800_0000, 1,  0);
        run_op("srl",    32'h8000_0000,32'd4,        3'b101, 1'b0, 3'b111, 1'b0, 32'h0800_0000, 1,  0);
        run_op("sll",    32'd1,        32'd31,       3'b001, 1'b0, 3'b110, 1'b0, 32'h8000_0000, 1,  0);
        run_op("and",    32'h0000_F0F0,32'h0000_FF00,3'b000, 1'b0, 3'b010, 1'b0, 32'h0000_F000, 1,  0);
        run_op("xor",    32'h0000_F0F0,32'h0000_FF00,3'b000, 1'b0, 3'b100, 1'b0, 32'h0000_0FF0, 1,  0);
        run_op("slt",    32'hFFFF_FFFF,32'd1,        3'b010, 1'b0, 3'b101, 1'b0, 32'd1,         1,  0);
        run_op("sltu",   32'd1,        32'hFFFF_FFFF,3'b011, 1'b0, 3'b101, 1'b0, 32'd1,         1,  0);
        run_op("mulh",   32'hFFFF_FFFE,32'd3,        3'b001, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFF, 34, 0);
        run_op("mul",    32'hFFFF_FFFE,32'd3,        3'b000, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFA, 34, 0);
        run_op("mulhu",  32'hFFFF_FFFF,32'hFFFF_FFFF,3'b011, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhsu", 32'hFFFF_FFFF,32'hFFFF_FFFF,3'b010, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFF, 34, 0);
        run_op("div",    32'hFFFF_FFF9,32'd2,        3'b100, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFD, 34, 0);
        run_op("rem",    32'hFFFF_FFF9,32'd2,        3'b110, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFF, 34, 0);
        run_op("divu_z", 32'd5,        32'd0,        3'b101, 1'b0, 3'b000, 1'b1, 32'hFFFF_FFFF, 1,  0);
        run_op("remu_z", 32'd5,        32'd0,        3'b111, 1'b0, 3'b000, 1'b1, 32'd5,         1,  0);
        run_op("div_ov", 32'h8000_0000,32'hFFFF_FFFF,3'b100, 1'b0, 3'b000, 1'b1, 32'h8000_0000, 1,  0);
        run_op("rem_ov", 32'h8000_0000,32'hFFFF_FFFF,3'b110, 1'b0, 3'b000, 1'b1, 32'h0,         1,  0);
        run_op("divu_bp",32'd100,      32'd7,        3'b101, 1'b0, 3'b000, 1'b1, 32'd14,        34, 10);

        // Abort a multiply in CALC at cnt=10
        @(negedge clk);
        A = 32'd3; B = 32'd5; funct3 = 3'b000; ALUControl = 3'b000; is_muldiv = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_busy_pre", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", {31'b0, in_ready}, 32'h1);
        check("abort_out_valid", {31'b0, out_valid}, 32'h0);
        check("abort_result", Result, 32'h0);
        check("abort_zero", {31'b0, Zero}, 32'h1);
        ov_seen = 0;
        out_ready = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        out_ready = 1'b0;
        check("abort_no_result", 32'(ov_seen), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
